// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the write scheduler and its arbiter.
//
// Contents:
//   REG_ADDR_W  default register address width
//   REG_DATA_W  default register data width
//   ZERO_REG    address of the hard-wired zero register
//   wb_req_t    one writeback request (valid, addr, data)
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wsched_arbiter.sv
// Two-way grant logic for the register-file write port.
//
// Build option (macro WSCHED_RR_EN):
//   defined   - round-robin on contention; the pointer flips after every
//               contended grant and holds on uncontended grants.
//   undefined - fixed priority, req0 always wins; no pointer register and
//               no clock/reset ports.
//
// Ports:
//   clk, rst_n  clock and async active-low reset (round-robin build only)
//   req0, req1  request valids from wb0 (ALU) and wb1 (load unit)
//   grant0/1    one-hot grant, combinational from the requests
module wsched_arbiter (
`ifdef WSCHED_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

`ifdef WSCHED_RR_EN
  // Pointer value 0 favours req0, 1 favours req1.
  logic rr_ptr;
  logic contended;

  assign contended = req0 && req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (contended) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign grant0 = req0 && (!req1 || !rr_ptr);
  assign grant1 = req1 && (!req0 ||  rr_ptr);
`else
  assign grant0 = req0;
  assign grant1 = req1 && !req0;
`endif

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file's single write port between the ALU (wb0) and the
// load/multi-cycle unit (wb1), registers the winning write into a one-deep
// output stage, and tracks a per-register busy scoreboard for RAW stalls.
//
// Build option: WSCHED_RR_EN selects round-robin arbitration (see
// wsched_arbiter); otherwise wb0 has fixed priority.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wb0_valid/addr/data/ready   ALU write request and its accept
//   wb1_valid/addr/data/ready   load-unit write request and its accept
//   sb_set_valid/addr           issue marks a destination as pending
//   rs1_addr/rs2_addr           source register queries
//   rs1_busy/rs2_busy           scoreboard bits for the queried registers
//   rf_we/rf_wa/rf_wd           register file write port
//   conflict_cnt                saturating count of contended cycles
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              sb_set_valid,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              commit;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;

  wsched_arbiter u_arbiter (
`ifdef WSCHED_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
`endif
    .req0   (wb0_valid),
    .req1   (wb1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign accept    = grant0 || grant1;
  assign sel_addr  = grant0 ? wb0_addr : wb1_addr;
  assign sel_data  = grant0 ? wb0_data : wb1_data;

  // x0 writes are accepted (the requester must not stall) but never reach
  // the register file; address/data then hold like an idle cycle.
  assign commit = accept && (sel_addr != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= commit;
      if (commit) begin
        rf_wa <= sel_addr;
        rf_wd <= sel_data;
      end
    end
  end

  // Clear on the edge that commits the write, then apply a new set so a
  // younger producer of the same register keeps it pending.
  always_comb begin
    busy_next = busy;
    if (rf_we) begin
      busy_next[rf_wa] = 1'b0;
    end
    if (sb_set_valid) begin
      busy_next[sb_set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // The write committing this cycle still reads as busy; issue sees it
  // free only from the following cycle.
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (wb0_valid && wb1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
